sqrt_iter_engine: RTL and testbench
===================================

Name: sqrt_iter_engine

Overview:
Parametrised, handshaked successor to the fixed 14-bit square-root finder. Computes floor(sqrt(x)) of an unsigned WIDTH-bit operand with the bit-pair restoring method, producing one root bit per cycle. Also returns the remainder and offers an optional per-request round-to-nearest mode. Sits between an upstream producer and a downstream consumer, both using valid/ready handshakes.

Parameters:
WIDTH, 14, operand width in bits (>=2; odd values are zero-extended internally to WIDTH+1)
ROOT_W, (WIDTH+1)/2, root width; derived, not to be overridden

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  operand present
in_ready  out  1  engine can accept an operand
in_data  in  WIDTH  unsigned operand x
in_round  in  1  1 = round root to nearest, sampled with operand
out_valid  out  1  result present
out_ready  in  1  consumer accepts result
out_root  out  ROOT_W  root (floor, or rounded when in_round was set)
out_rem  out  ROOT_W+1  x - floor(sqrt(x))^2, always the truncated remainder
out_sat  out  1  rounding overflowed root width; out_root saturated

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; in_ready=1 on the next cycle; out_valid=0; out_root=0; out_rem=0; out_sat=0; iteration counter=0.
- A reset mid-computation or while holding a result discards the work silently; no partial result appears.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready: latch in_data (zero-extended to 2*ROOT_W) and in_round; clear root/remainder accumulators; cnt=ROOT_W-1; go to CALC.
  - CALC: in_ready=0. Each cycle: trial = {rem, next two operand MSBs} - {root, 2'b01}. If trial >= 0: rem=trial, root={root,1}; else rem keeps the shifted value, root={root,0}. When cnt==0, go to DONE; otherwise cnt-1.
  - DONE: out_valid=1; in_ready=0. On out_ready, go to IDLE. No back-to-back accept in DONE.
- Latency: out_valid rises exactly ROOT_W cycles after the accept edge (7 for WIDTH=14). Throughput is one result per ROOT_W+2 cycles minimum.
- Rounding at the DONE entry edge: if the round flag is set and rem > root, then root+1. This is exact because x > r^2+r is equivalent to sqrt(x) >= r+0.5.
  - If root is all ones, out_root stays 2^ROOT_W-1 and out_sat=1.
  - out_sat=0 in every other case.
- out_root, out_rem and out_sat are registered. They are stable and valid only while out_valid=1 and must not change while out_valid&!out_ready. They are held at their last values in IDLE.
- in_data and in_round are sampled only at the accept edge; later changes have no effect.
- Remainder register width is ROOT_W+2 internally, for the sign of the trial subtraction. out_rem <= 2*root always fits in ROOT_W+1.
- Only x=0 yields root 0 with rem 0; no special casing is needed.

Decomposition:
- Package sqrt_pkg holds:
  - the state enum (IDLE, CALC, DONE)
  - a function root_width(w) = (w+1)/2
  - a function for the counter width, clog2(ROOT_W)
- Sub-module sqrt_step is a natural split: combinational, one restoring iteration. Inputs are rem, root and the operand bit-pair; outputs are the next rem and next root bit. It is reusable for a future unrolled/pipelined variant.

Test Plan:
1. WIDTH=14, x=3, round=0, out_ready=1 -> out_valid 7 cycles after accept, root=1, rem=2, sat=0; repeat with round=1 -> root=2, rem=2.
2. x=16383, round=1 -> root=127, rem=254, sat=1; round=0 -> root=127, sat=0. Also x=0 -> root=0, rem=0.
3. x=10000 -> root=100, rem=0; x=99, round=1 -> root=10, rem=18. Hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0, in_valid pulses ignored.
4. Assert rst 3 cycles after accepting x=99 -> the next cycle shows out_valid=0, outputs 0, in_ready=1. A fresh x=3 then completes normally (root=1, rem=2).
5. WIDTH=9 (ROOT_W=5): x=511 -> root=22, rem=27, latency 5; round=1 -> root=23 (27>22). Random sweep of 1000 operands at WIDTH=14 against a reference model, with out_ready randomly stalled.

Source files
------------

// File: rtl/sqrt_pkg.sv
// Shared types and sizing helpers for the iterative square-root engine.
// Imported by the engine top and its restoring-step datapath.
package sqrt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  function automatic int root_width(input int w);
    return (w + 1) / 2;
  endfunction

  // A one-bit root still needs a one-bit counter.
  function automatic int cnt_width(input int rw);
    return (rw > 1) ? $clog2(rw) : 1;
  endfunction

endpackage

// File: rtl/sqrt_step.sv
// One bit-pair restoring square-root iteration, purely combinational.
// Shared by the iterative engine and any future unrolled variant.
module sqrt_step #(
  parameter int ROOT_W = 7
) (
  input  logic [ROOT_W+1:0] rem,
  input  logic [ROOT_W-1:0] root,
  input  logic [1:0]        pair,
  output logic [ROOT_W+1:0] rem_next,
  output logic              root_bit
);

  logic [ROOT_W+3:0] cand;
  logic [ROOT_W+3:0] sub;
  logic [ROOT_W+1:0] diff;

  assign cand = {rem, pair};
  assign sub  = {2'b00, root, 2'b01};

  // A successful trial always leaves a remainder that fits the register.
  assign diff     = cand[ROOT_W+1:0] - sub[ROOT_W+1:0];
  assign root_bit = (cand >= sub);
  assign rem_next = root_bit ? diff : cand[ROOT_W+1:0];

endmodule

// File: rtl/sqrt_iter_engine.sv
// Handshaked floor/rounded integer square root, one root bit per cycle.
// Result registers hold their values until the next result is loaded.
module sqrt_iter_engine
  import sqrt_pkg::*;
#(
  parameter int WIDTH  = 14,
  parameter int ROOT_W = root_width(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_round,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ROOT_W-1:0] out_root,
  output logic [ROOT_W:0]   out_rem,
  output logic              out_sat
);

  localparam int XW = 2 * ROOT_W;
  localparam int CW = cnt_width(ROOT_W);

  state_t            state;
  logic [XW-1:0]     x;
  logic              rnd;
  logic [ROOT_W+1:0] rem;
  logic [ROOT_W-1:0] root;
  logic [CW-1:0]     cnt;

  logic [ROOT_W+1:0] rem_nxt;
  logic              bit_nxt;
  logic [ROOT_W-1:0] root_nxt;
  logic [ROOT_W-1:0] fin_root;
  logic              fin_sat;
  logic              up;

  sqrt_step #(
    .ROOT_W(ROOT_W)
  ) u_step (
    .rem     (rem),
    .root    (root),
    .pair    (x[XW-1 -: 2]),
    .rem_next(rem_nxt),
    .root_bit(bit_nxt)
  );

  assign root_nxt = (root << 1) | ROOT_W'(bit_nxt);

  // x > r*r + r exactly when sqrt(x) >= r + 0.5.
  assign up = rnd && (rem_nxt > {2'b00, root_nxt});

  always_comb begin
    fin_root = root_nxt;
    fin_sat  = 1'b0;
    if (up) begin
      if (&root_nxt) begin
        fin_sat = 1'b1;
      end else begin
        fin_root = root_nxt + ROOT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_root  <= '0;
      out_rem   <= '0;
      out_sat   <= 1'b0;
      cnt       <= '0;
      x         <= '0;
      rnd       <= 1'b0;
      rem       <= '0;
      root      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            x        <= XW'(in_data);
            rnd      <= in_round;
            rem      <= '0;
            root     <= '0;
            cnt      <= CW'(ROOT_W - 1);
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          x    <= x << 2;
          rem  <= rem_nxt;
          root <= root_nxt;
          if (cnt == '0) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_root  <= fin_root;
            out_rem   <= rem_nxt[ROOT_W:0];
            out_sat   <= fin_sat;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_iter_engine.sv
// Scoreboard bench for sqrt_iter_engine at WIDTH=14 and WIDTH=9.
// Expected results come from an independent integer sqrt model.
module tb_sqrt_iter_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [13:0] in_data;
  logic        in_round;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  out_root;
  logic [7:0]  out_rem;
  logic        out_sat;

  logic        b_in_valid;
  logic        b_in_ready;
  logic [8:0]  b_in_data;
  logic        b_in_round;
  logic        b_out_valid;
  logic        b_out_ready;
  logic [4:0]  b_out_root;
  logic [5:0]  b_out_rem;
  logic        b_out_sat;

  sqrt_iter_engine #(
    .WIDTH(14)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_round (in_round),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_root (out_root),
    .out_rem  (out_rem),
    .out_sat  (out_sat)
  );

  sqrt_iter_engine #(
    .WIDTH(9)
  ) dut_b (
    .clk      (clk),
    .rst      (rst),
    .in_valid (b_in_valid),
    .in_ready (b_in_ready),
    .in_data  (b_in_data),
    .in_round (b_in_round),
    .out_valid(b_out_valid),
    .out_ready(b_out_ready),
    .out_root (b_out_root),
    .out_rem  (b_out_rem),
    .out_sat  (b_out_sat)
  );

  typedef struct {
    int root;
    int rem;
    int sat;
    int acc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   mode   = 0;
  bit   prev_ov = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, got, want);
    end
  endtask

  function automatic exp_t model(input int x, input bit r);
    exp_t e;
    int s = 0;
    while ((s + 1) * (s + 1) <= x) s++;
    e.root = s;
    e.rem  = x - s * s;
    e.sat  = 0;
    e.acc  = 0;
    if (r && (4 * x >= (2 * s + 1) * (2 * s + 1))) begin
      if (s == 127) e.sat = 1;
      else e.root = s + 1;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    case (mode)
      0: out_ready = 1'b1;
      1: out_ready = ($urandom_range(0, 2) != 0);
      default: out_ready = 1'b0;
    endcase
    if (!rst) begin
      if (out_valid && !prev_ov && q.size() > 0)
        check("latency", cyc - q[0].acc - 1, 7);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("spurious", 1, 0);
        end else begin
          e = q.pop_front();
          check("root", out_root, e.root);
          check("rem", out_rem, e.rem);
          check("sat", out_sat, e.sat);
        end
      end
    end
    prev_ov = out_valid;
  end

  task automatic send(input logic [13:0] x, input logic r, input bit push);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = x;
    in_round = r;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
    end else if (push) begin
      e     = model(int'(x), r);
      e.acc = cyc;
      q.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 14'($urandom);
    in_round = 1'($urandom);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain", q.size(), 0);
  endtask

  task automatic run_b(input logic [8:0] x, input logic r, input int er,
                       input int erem, input int esat);
    int n = 0;
    @(negedge clk);
    b_in_valid = 1'b1;
    b_in_data  = x;
    b_in_round = r;
    while (!b_in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("b_accept", b_in_ready, 1);
    @(negedge clk);
    b_in_valid = 1'b0;
    n = 1;
    while (!b_out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("b_latency", n - 1, 5);
    check("b_root", b_out_root, er);
    check("b_rem", b_out_rem, erem);
    check("b_sat", b_out_sat, esat);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_data     = '0;
    in_round    = 1'b0;
    out_ready   = 1'b1;
    b_in_valid  = 1'b0;
    b_in_data   = '0;
    b_in_round  = 1'b0;
    b_out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_root", out_root, 0);
    check("rst_rem", out_rem, 0);
    check("rst_sat", out_sat, 0);
    rst = 1'b0;

    send(14'd3, 1'b0, 1'b1);
    wait_drain();
    send(14'd3, 1'b1, 1'b1);
    wait_drain();
    send(14'd16383, 1'b1, 1'b1);
    send(14'd16383, 1'b0, 1'b1);
    send(14'd0, 1'b0, 1'b1);
    wait_drain();
    send(14'd10000, 1'b0, 1'b1);
    wait_drain();

    mode = 2;
    send(14'd99, 1'b1, 1'b1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", out_valid, 1);
      check("hold_root", out_root, 10);
      check("hold_rem", out_rem, 18);
      check("hold_in_ready", in_ready, 0);
      in_valid = i[0];
      in_data  = 14'd5;
      @(negedge clk);
    end
    in_valid = 1'b0;
    mode = 0;
    wait_drain();

    send(14'd99, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_valid", out_valid, 0);
    check("midrst_root", out_root, 0);
    check("midrst_rem", out_rem, 0);
    check("midrst_sat", out_sat, 0);
    check("midrst_in_ready", in_ready, 1);
    send(14'd3, 1'b0, 1'b1);
    wait_drain();

    run_b(9'd511, 1'b0, 22, 27, 0);
    run_b(9'd511, 1'b1, 23, 27, 0);

    mode = 1;
    for (int i = 0; i < 1000; i++) begin
      logic [13:0] x;
      x = 14'($urandom_range(0, 16383));
      if (i == 0) x = 14'd16383;
      if (i == 1) x = 14'd0;
      if (i == 2) x = 14'd16128;
      send(x, 1'($urandom_range(0, 1)), 1'b1);
    end
    wait_drain();
    mode = 0;
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
